// File: rtl/pc_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_branch_unit_if
// Brief    : Control, operand and status bundle between the decode/ALU side
//            and the program-counter stage. The master drives the control and
//            operand inputs; the slave (pc_branch_unit) drives the PC status.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_branch_unit_if #(
  parameter int CNT_WIDTH = 8
);

  // Control and operand inputs to the PC stage
  logic                 stall;
  logic                 branch;
  logic                 zero;
  logic                 jump;
  logic                 halt;
  logic                 resume;
  logic [15:0]          imm_ext;
  logic [15:0]          jump_addr;

  // Status outputs from the PC stage
  logic [15:0]          pc;
  logic [15:0]          pc_plus1;
  logic                 taken;
  logic                 halted;
  logic [CNT_WIDTH-1:0] redirect_cnt;

  // Decode/ALU side: drives controls, observes PC status
  modport master (
    output stall,
    output branch,
    output zero,
    output jump,
    output halt,
    output resume,
    output imm_ext,
    output jump_addr,
    input  pc,
    input  pc_plus1,
    input  taken,
    input  halted,
    input  redirect_cnt
  );

  // PC stage side
  modport slave (
    input  stall,
    input  branch,
    input  zero,
    input  jump,
    input  halt,
    input  resume,
    input  imm_ext,
    input  jump_addr,
    output pc,
    output pc_plus1,
    output taken,
    output halted,
    output redirect_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_branch_unit
// Brief    : Program-counter stage. Holds the PC and selects the next value
//            from sequential, PC-relative branch, absolute jump or hold, under
//            a two-state RUN/HALT controller. Keeps a saturating count of
//            applied redirects and a one-cycle "taken" pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          CNT_WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pc_branch_unit_if.slave   bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]           S_RUN      = 1'b0;
  localparam logic [0:0]           S_HALT     = 1'b1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]          C_PC_ONE   = 16'h0001;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0]          pc_q,    pc_d;
  logic [0:0]           state_q, state_d;
  logic                 taken_q, taken_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [15:0] pc_inc;      // pc + 1, carry discarded
  logic [15:0] branch_tgt;  // branch target, relative to pc + 1
  logic        redirect;    // a jump or taken branch is applied this edge

  // Both additions are modulo 2^16; a negative offset wraps backward naturally.
  assign pc_inc     = pc_q + C_PC_ONE;
  assign branch_tgt = pc_inc + bus.imm_ext;

  // Next-state selection: RUN priority is stall > halt > jump > branch > seq.
  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    taken_d  = 1'b0;
    redirect = 1'b0;

    case (state_q)
      S_RUN: begin
        if (bus.stall) begin
          // Instruction not valid this cycle: hold everything.
          pc_d = pc_q;
        end else if (bus.halt) begin
          state_d = S_HALT;
        end else if (bus.jump) begin
          // A jump wins over a coincident taken branch, counted once.
          pc_d     = bus.jump_addr;
          taken_d  = 1'b1;
          redirect = 1'b1;
        end else if (bus.branch && bus.zero) begin
          pc_d     = branch_tgt;
          taken_d  = 1'b1;
          redirect = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end

      S_HALT: begin
        // Only resume is honoured; execution continues after the HALT.
        if (bus.resume) begin
          state_d = S_RUN;
          pc_d    = pc_inc;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Redirect counter saturates at all-ones and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (redirect && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= S_RUN;
      taken_q <= 1'b0;
      cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc           = pc_q;
  assign bus.pc_plus1     = pc_inc;
  assign bus.taken        = taken_q;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.redirect_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_branch_unit
// Brief    : Directed self-checking bench for pc_branch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

  localparam int CNT_WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [CNT_WIDTH-1:0] exp_cnt;

  pc_branch_unit_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  pc_branch_unit #(
    .RESET_PC  (16'h0000),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall     = 1'b0;
    bus.branch    = 1'b0;
    bus.zero      = 1'b0;
    bus.jump      = 1'b0;
    bus.halt      = 1'b0;
    bus.resume    = 1'b0;
    bus.imm_ext   = 16'h0000;
    bus.jump_addr = 16'h0000;
  endtask

  // Single jump to a known PC; the redirect is counted in exp_cnt.
  task automatic jump_to(input logic [15:0] addr);
    idle_inputs();
    bus.jump      = 1'b1;
    bus.jump_addr = addr;
    step();
    idle_inputs();
    if (exp_cnt != {CNT_WIDTH{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (bus.pc !== addr) begin
      n_errors++;
      $display("FAIL jump_to pc: got %h expected %h", bus.pc, addr);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.pc !== 16'h0000 || bus.taken !== 1'b0 || bus.halted !== 1'b0 ||
        bus.redirect_cnt !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_state: pc=%h taken=%b halted=%b cnt=%h expected 0000/0/0/00",
               bus.pc, bus.taken, bus.halted, bus.redirect_cnt);
    end
    n_checks++;
    if (bus.pc_plus1 !== 16'h0001) begin
      n_errors++;
      $display("FAIL reset_pc_plus1: got %h expected 0001", bus.pc_plus1);
    end
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (bus.pc !== 16'(i) || bus.taken !== 1'b0 || bus.redirect_cnt !== 8'h00) begin
        n_errors++;
        $display("FAIL seq_run[%0d]: pc=%h taken=%b cnt=%h expected %h/0/00",
                 i, bus.pc, bus.taken, bus.redirect_cnt, 16'(i));
      end
    end
  endtask

  task automatic test_forward_branch();
    // Walk sequentially from 0003 up to 0010.
    for (int i = 0; i < 13; i++) step();
    n_checks++;
    if (bus.pc !== 16'h0010) begin
      n_errors++;
      $display("FAIL fwd_setup pc: got %h expected 0010", bus.pc);
    end
    bus.branch  = 1'b1;
    bus.zero    = 1'b1;
    bus.imm_ext = 16'h0012;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h0023 || bus.taken !== 1'b1 || bus.redirect_cnt !== 8'h01) begin
      n_errors++;
      $display("FAIL fwd_taken: pc=%h taken=%b cnt=%h expected 0023/1/01",
               bus.pc, bus.taken, bus.redirect_cnt);
    end
    exp_cnt = 8'h01;
    step();
    n_checks++;
    if (bus.pc !== 16'h0024 || bus.taken !== 1'b0) begin
      n_errors++;
      $display("FAIL fwd_pulse_end: pc=%h taken=%b expected 0024/0", bus.pc, bus.taken);
    end
    // Same branch with zero clear falls through.
    jump_to(16'h0010);
    bus.branch  = 1'b1;
    bus.zero    = 1'b0;
    bus.imm_ext = 16'h0012;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h0011 || bus.taken !== 1'b0 || bus.redirect_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL fwd_not_taken: pc=%h taken=%b cnt=%h expected 0011/0/%h",
               bus.pc, bus.taken, bus.redirect_cnt, exp_cnt);
    end
  endtask

  task automatic test_backward_wrap();
    jump_to(16'h0080);
    bus.branch  = 1'b1;
    bus.zero    = 1'b1;
    bus.imm_ext = 16'hFF85;
    step();
    idle_inputs();
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (bus.pc !== 16'h0006 || bus.taken !== 1'b1 || bus.redirect_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL back_branch: pc=%h taken=%b cnt=%h expected 0006/1/%h",
               bus.pc, bus.taken, bus.redirect_cnt, exp_cnt);
    end
    jump_to(16'h0000);
    bus.branch  = 1'b1;
    bus.zero    = 1'b1;
    bus.imm_ext = 16'hFFA4;
    step();
    idle_inputs();
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (bus.pc !== 16'hFFA5) begin
      n_errors++;
      $display("FAIL back_wrap_low: pc=%h expected FFA5", bus.pc);
    end
    jump_to(16'hFFFF);
    n_checks++;
    if (bus.pc_plus1 !== 16'h0000) begin
      n_errors++;
      $display("FAIL pc_plus1_wrap: got %h expected 0000", bus.pc_plus1);
    end
    step();
    n_checks++;
    if (bus.pc !== 16'h0000 || bus.taken !== 1'b0) begin
      n_errors++;
      $display("FAIL seq_wrap: pc=%h taken=%b expected 0000/0", bus.pc, bus.taken);
    end
  endtask

  task automatic test_priority();
    jump_to(16'h0500);
    bus.stall     = 1'b1;
    bus.jump      = 1'b1;
    bus.halt      = 1'b1;
    bus.jump_addr = 16'h9999;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h0500 || bus.taken !== 1'b0 || bus.halted !== 1'b0 ||
        bus.redirect_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL stall_hold: pc=%h taken=%b halted=%b cnt=%h expected 0500/0/0/%h",
               bus.pc, bus.taken, bus.halted, bus.redirect_cnt, exp_cnt);
    end
    bus.jump      = 1'b1;
    bus.branch    = 1'b1;
    bus.zero      = 1'b1;
    bus.imm_ext   = 16'h0040;
    bus.jump_addr = 16'h1234;
    step();
    idle_inputs();
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (bus.pc !== 16'h1234 || bus.taken !== 1'b1 || bus.redirect_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL jump_over_branch: pc=%h taken=%b cnt=%h expected 1234/1/%h",
               bus.pc, bus.taken, bus.redirect_cnt, exp_cnt);
    end
    // resume while running is a plain sequential step
    bus.resume = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h1235 || bus.halted !== 1'b0 || bus.taken !== 1'b0) begin
      n_errors++;
      $display("FAIL resume_in_run: pc=%h halted=%b taken=%b expected 1235/0/0",
               bus.pc, bus.halted, bus.taken);
    end
  endtask

  task automatic test_halt_resume();
    jump_to(16'h0040);
    bus.halt = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h0040 || bus.halted !== 1'b1 || bus.taken !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_enter: pc=%h halted=%b taken=%b expected 0040/1/0",
               bus.pc, bus.halted, bus.taken);
    end
    for (int i = 0; i < 5; i++) begin
      bus.jump      = 1'b1;
      bus.branch    = 1'b1;
      bus.zero      = 1'b1;
      bus.jump_addr = 16'hBEEF;
      bus.imm_ext   = 16'h0100;
      step();
      n_checks++;
      if (bus.pc !== 16'h0040 || bus.halted !== 1'b1 || bus.taken !== 1'b0 ||
          bus.redirect_cnt !== exp_cnt) begin
        n_errors++;
        $display("FAIL halt_hold[%0d]: pc=%h halted=%b taken=%b cnt=%h expected 0040/1/0/%h",
                 i, bus.pc, bus.halted, bus.taken, bus.redirect_cnt, exp_cnt);
      end
    end
    idle_inputs();
    bus.resume = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h0041 || bus.halted !== 1'b0 || bus.taken !== 1'b0) begin
      n_errors++;
      $display("FAIL resume: pc=%h halted=%b taken=%b expected 0041/0/0",
               bus.pc, bus.halted, bus.taken);
    end
    bus.halt = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.pc !== 16'h0041 || bus.halted !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_again: pc=%h halted=%b expected 0041/1", bus.pc, bus.halted);
    end
    rst        = 1'b1;
    bus.resume = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    exp_cnt = '0;
    n_checks++;
    if (bus.pc !== 16'h0000 || bus.halted !== 1'b0 || bus.taken !== 1'b0 ||
        bus.redirect_cnt !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mid_halt: pc=%h halted=%b taken=%b cnt=%h expected 0000/0/0/00",
               bus.pc, bus.halted, bus.taken, bus.redirect_cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_n;
    int bad;
    logic [15:0] addr;
    exp_n = 0;
    bad   = 0;
    for (int i = 0; i < 260; i++) begin
      addr          = 16'h2000 + 16'(i);
      bus.jump      = 1'b1;
      bus.jump_addr = addr;
      step();
      exp_n = (exp_n < 255) ? exp_n + 1 : 255;
      n_checks++;
      if (bus.taken !== 1'b1 || bus.pc !== addr || bus.redirect_cnt !== 8'(exp_n)) begin
        n_errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL sat_jump[%0d]: pc=%h taken=%b cnt=%h expected %h/1/%h",
                   i, bus.pc, bus.taken, bus.redirect_cnt, addr, 8'(exp_n));
      end
    end
    idle_inputs();
    step();
    n_checks++;
    if (bus.redirect_cnt !== 8'hFF || bus.taken !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_hold: cnt=%h taken=%b expected FF/0", bus.redirect_cnt, bus.taken);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = '0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_forward_branch();
    test_backward_wrap();
    test_priority();
    test_halt_resume();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
